cnt_ctrl: RTL

CNT_CTRL -- requirements
Module: cnt_ctrl

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_prescaler.sv | 68 ++++++
 rtl/cnt_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer count-enable controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_e    - controller FSM states (IDLE / RUN / HALT)
//   DIV_MAX    - largest usable prescaler exponent
//   PSC_W      - prescaler counter width
//   psc_limit  - terminal count (2^div_val)-1 with the exponent clamped to DIV_MAX
package timer_pkg;

   localparam int DIV_MAX = 8;
   localparam int PSC_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   // Exponents above DIV_MAX saturate, so the limit never exceeds the counter range.
   function automatic logic [PSC_W-1:0] psc_limit(input logic [3:0] div_val);
      logic [3:0]     exp_v;
      logic [PSC_W:0] pow_v;
      logic [PSC_W:0] lim_v;
      exp_v = (div_val > 4'(DIV_MAX)) ? 4'(DIV_MAX) : div_val;
      pow_v = {{PSC_W{1'b0}}, 1'b1} << exp_v;
      lim_v = pow_v - {{PSC_W{1'b0}}, 1'b1};
      return lim_v[PSC_W-1:0];
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts RUN cycles and flags the terminal count of a 2^div_val divider.
// Latency: tick_o is decoded from registers only; input changes take effect after one edge.
// Backpressure: none; the counter advances only when the controller reports RUN.
//
// Ports:
//   sys_clk, sys_rst  - clock and synchronous active-high reset
//   idle_i, run_i     - controller is in IDLE / RUN this cycle (HALT when neither)
//   div_en_i          - prescaler enable
//   div_val_i         - prescaler exponent
//   cnt_clr_i         - counter clear strobe (restarts the prescaler)
//   tdr_wr_en_i       - counter write strobe (restarts the prescaler)
//   tick_o            - divider output: high when undivided or at terminal count
module timer_prescaler
   import timer_pkg::*;
(
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       idle_i,
   input  logic       run_i,
   input  logic       div_en_i,
   input  logic [3:0] div_val_i,
   input  logic       cnt_clr_i,
   input  logic       tdr_wr_en_i,
   output logic       tick_o
);

   logic [PSC_W-1:0] int_cnt_q;
   logic [PSC_W-1:0] int_cnt_d;
   logic [3:0]       div_val_q;
   logic             div_en_q;
   logic [PSC_W-1:0] limit;
   logic             at_limit;
   logic             restart;

   // The limit is taken from the registered div_val so tick_o has no input path;
   // any div_val change forces a restart, so the one-cycle lag never miscounts.
   assign limit    = psc_limit(div_val_q);
   assign at_limit = (int_cnt_q == limit);
   assign restart  = cnt_clr_i | tdr_wr_en_i
                   | (div_val_i != div_val_q)
                   | (div_en_i  != div_en_q);

   always_comb begin
      int_cnt_d = int_cnt_q;
      if (idle_i) begin
         int_cnt_d = '0;
      end else if (restart) begin
         int_cnt_d = '0;
      end else if (run_i) begin
         int_cnt_d = at_limit ? '0 : int_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         int_cnt_q <= '0;
         div_val_q <= '0;
         div_en_q  <= 1'b0;
      end else begin
         int_cnt_q <= int_cnt_d;
         div_val_q <= div_val_i;
         div_en_q  <= div_en_i;
      end
   end

   assign tick_o = ~div_en_q | at_limit;

endmodule

// File: rtl/cnt_ctrl.sv
// Count-enable controller: IDLE/RUN/HALT FSM gating a prescaled enable to a 64-bit counter.
// Latency: outputs decode registered state only; inputs act on the next rising edge.
// Backpressure: none; a qualified debugger halt freezes the prescaler and drops cnt_en.
//
// Ports:
//   sys_clk, sys_rst   - clock and synchronous active-high reset
//   timer_en           - run the timer
//   div_en, div_val    - prescaler enable and exponent (ratio 2^div_val, clamped at 2^8)
//   debug_mode         - qualifies halt_req
//   halt_req           - debugger halt request
//   cnt_clr, tdr_wr_en - counter clear / write strobes, both restart the prescaler
//   cnt_en             - count-enable pulse to the counter
//   halt_ack           - high while halted
module cnt_ctrl
   import timer_pkg::*;
(
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       timer_en,
   input  logic       div_en,
   input  logic [3:0] div_val,
   input  logic       debug_mode,
   input  logic       halt_req,
   input  logic       cnt_clr,
   input  logic       tdr_wr_en,
   output logic       cnt_en,
   output logic       halt_ack
);

   state_e state_q;
   logic   halt_ack_q;
   logic   halt_hit;
   logic   st_idle;
   logic   st_run;
   logic   psc_tick;

   assign halt_hit = debug_mode & halt_req;
   assign st_idle  = (state_q == IDLE);
   assign st_run   = (state_q == RUN);

   // All three states share one transition rule: a qualified halt request wins,
   // otherwise timer_en chooses RUN or IDLE. For HALT this is exactly "leave once
   // the request is withdrawn or debug mode drops, towards RUN or IDLE by timer_en".
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         halt_ack_q <= 1'b0;
      end else if (halt_hit) begin
         state_q    <= HALT;
         halt_ack_q <= 1'b1;
      end else if (timer_en) begin
         state_q    <= RUN;
         halt_ack_q <= 1'b0;
      end else begin
         state_q    <= IDLE;
         halt_ack_q <= 1'b0;
      end
   end

   timer_prescaler u_psc (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .idle_i      (st_idle),
      .run_i       (st_run),
      .div_en_i    (div_en),
      .div_val_i   (div_val),
      .cnt_clr_i   (cnt_clr),
      .tdr_wr_en_i (tdr_wr_en),
      .tick_o      (psc_tick)
   );

   assign cnt_en   = st_run & psc_tick;
   assign halt_ack = halt_ack_q;

endmodule
